// File: rtl/mmu_mem_arbiter_pkg.sv
// Shared types and defaults for the MMU-side data-cache port arbiter.
package ariane_pkg;

    localparam int unsigned DEFAULT_NUM_PORTS = 3;
    localparam int unsigned PADDR_W           = 56;
    localparam int unsigned DATA_W            = 64;
    localparam int unsigned BE_W              = 8;

    typedef struct packed {
        logic [PADDR_W-1:0] addr;
        logic               we;
        logic [DATA_W-1:0]  wdata;
        logic [BE_W-1:0]    be;
    } mem_port_req_t;

endpackage

// File: rtl/mmu_arb_id_fifo.sv
// Small circular FIFO holding the requester index of each issued transaction.
module mmu_arb_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        // Simultaneous push and pop leaves the count untouched.
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmu_mem_arbiter.sv
// Round-robin arbiter sharing one D$ port among MMU requesters, with grant lock
// and in-order response routing through an ID FIFO.
module mmu_mem_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = DEFAULT_NUM_PORTS,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0][PADDR_W-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_i,
    input  logic [NUM_PORTS-1:0][BE_W-1:0]    be_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [DATA_W-1:0]                 rdata_o,
    output logic                              mem_req_o,
    output logic [PADDR_W-1:0]                mem_addr_o,
    output logic                              mem_we_o,
    output logic [DATA_W-1:0]                 mem_wdata_o,
    output logic [BE_W-1:0]                   mem_be_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rvalid_i,
    input  logic [DATA_W-1:0]                 mem_rdata_i,
    output logic                              err_o
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] locked_idx_q, locked_idx_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] sel;
    logic             sel_valid;
    logic             issue;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full_unused;
    mem_port_req_t    sel_req;

    // Selection: locked index wins, else first request at or after rr_ptr.
    always_comb begin
        int k;
        k         = 0;
        sel       = locked_idx_q;
        sel_valid = 1'b0;
        if (rst_i) begin
            sel_valid = 1'b0;
        end else if (locked_q) begin
            sel_valid = 1'b1;
        end else if (fifo_count < CNT_W'(MAX_OUTSTANDING)) begin
            for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
                k = (int'(rr_ptr_q) + i) % int'(NUM_PORTS);
                if (req_i[k]) begin
                    sel       = IDX_W'(k);
                    sel_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_req.addr  = addr_i[sel];
        sel_req.we    = we_i[sel];
        sel_req.wdata = wdata_i[sel];
        sel_req.be    = be_i[sel];
    end

    assign mem_req_o   = sel_valid;
    assign mem_addr_o  = sel_req.addr;
    assign mem_we_o    = sel_req.we;
    assign mem_wdata_o = sel_req.wdata;
    assign mem_be_o    = sel_req.be;
    assign rdata_o     = mem_rdata_i;
    assign err_o       = err_q;

    assign issue    = sel_valid && mem_gnt_i;
    assign fifo_pop = mem_rvalid_i && !fifo_empty && !rst_i;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (issue) begin
            gnt_o[sel] = 1'b1;
        end
        if (fifo_pop) begin
            rvalid_o[fifo_head] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        locked_d     = locked_q;
        locked_idx_d = locked_idx_q;
        err_d        = err_q;
        if (issue) begin
            rr_ptr_d = (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + IDX_W'(1);
        end
        if (sel_valid && !mem_gnt_i) begin
            locked_d     = 1'b1;
            locked_idx_d = sel;
        end else if (issue) begin
            locked_d = 1'b0;
        end
        if (mem_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            locked_q     <= 1'b0;
            locked_idx_q <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            locked_q     <= locked_d;
            locked_idx_q <= locked_idx_d;
            err_q        <= err_d;
        end
    end

    mmu_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue),
        .pop_i   (fifo_pop),
        .data_i  (sel),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed, table-driven bench for mmu_mem_arbiter (3 ports, 2 outstanding).
module tb_mmu_mem_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [2:0]       req_i;
    logic [2:0][55:0] addr_i;
    logic [2:0]       we_i;
    logic [2:0][63:0] wdata_i;
    logic [2:0][7:0]  be_i;
    logic [2:0]       gnt_o;
    logic [2:0]       rvalid_o;
    logic [63:0]      rdata_o;
    logic             mem_req_o;
    logic [55:0]      mem_addr_o;
    logic             mem_we_o;
    logic [63:0]      mem_wdata_o;
    logic [7:0]       mem_be_o;
    logic             mem_gnt_i;
    logic             mem_rvalid_i;
    logic [63:0]      mem_rdata_i;
    logic             err_o;

    int applied     = 0;
    int miscompares = 0;

    mmu_mem_arbiter #(
        .NUM_PORTS       (3),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        gnt;
        logic        rv;
        logic [63:0] rdata;
        logic        exp_mreq;
        int          exp_sel;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_rv;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [55:0] port_addr(input int p);
        return 56'h00_0012_3400_0000 + 56'(p) * 56'h40;
    endfunction

    function automatic logic [63:0] port_wdata(input int p);
        return 64'hA5A5_0000_0000_0000 | 64'(p + 1);
    endfunction

    function automatic logic [7:0] port_be(input int p);
        return 8'(8'h03 << p);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic gnt,
                                input logic rv, input logic [63:0] rdata, input logic emreq,
                                input int esel, input logic [2:0] egnt, input logic [2:0] erv,
                                input logic eerr);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.exp_mreq = emreq; v.exp_sel = esel; v.exp_gnt = egnt; v.exp_rv = erv;
        v.exp_err = eerr;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int n);
        @(negedge clk_i);
        rst_i        = v.rst;
        req_i        = v.req;
        mem_gnt_i    = v.gnt;
        mem_rvalid_i = v.rv;
        mem_rdata_i  = v.rdata;
        #1;
        applied++;
        if (mem_req_o !== v.exp_mreq) begin
            miscompares++;
            $display("FAIL v%0d mem_req got %b want %b", n, mem_req_o, v.exp_mreq);
        end
        if (gnt_o !== v.exp_gnt) begin
            miscompares++;
            $display("FAIL v%0d gnt got %b want %b", n, gnt_o, v.exp_gnt);
        end
        if (rvalid_o !== v.exp_rv) begin
            miscompares++;
            $display("FAIL v%0d rvalid got %b want %b", n, rvalid_o, v.exp_rv);
        end
        if (err_o !== v.exp_err) begin
            miscompares++;
            $display("FAIL v%0d err got %b want %b", n, err_o, v.exp_err);
        end
        if (v.exp_mreq && (mem_addr_o !== port_addr(v.exp_sel) ||
                           mem_wdata_o !== port_wdata(v.exp_sel) ||
                           mem_be_o !== port_be(v.exp_sel) ||
                           mem_we_o !== (v.exp_sel == 1))) begin
            miscompares++;
            $display("FAIL v%0d payload got addr %h want %h (port %0d)", n, mem_addr_o,
                     port_addr(v.exp_sel), v.exp_sel);
        end
        if (v.rv && rdata_o !== v.rdata) begin
            miscompares++;
            $display("FAIL v%0d rdata got %h want %h", n, rdata_o, v.rdata);
        end
    endtask

    initial begin
        int waited;
        rst_i = 1'b1; req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        for (int p = 0; p < 3; p++) begin
            addr_i[p]  = port_addr(p);
            wdata_i[p] = port_wdata(p);
            be_i[p]    = port_be(p);
            we_i[p]    = (p == 1);
        end

        //                rst req    g  rv rdata                   mreq sel gnt     rv      err
        vecs.push_back(mk(1, 3'b111, 1, 1, 64'h0,                  0,   0, 3'b000, 3'b000, 0)); // 0 reset
        vecs.push_back(mk(0, 3'b000, 0, 0, 64'h0,                  0,   0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b010, 1, 0, 64'h0,                  1,   1, 3'b010, 3'b000, 0)); // single
        vecs.push_back(mk(0, 3'b000, 0, 0, 64'h0,                  0,   0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'hDEAD_BEEF,          0,   0, 3'b000, 3'b010, 0));
        vecs.push_back(mk(0, 3'b100, 1, 0, 64'h0,                  1,   2, 3'b100, 3'b000, 0)); // 5 rr=0
        vecs.push_back(mk(0, 3'b111, 1, 1, 64'h1,                  1,   0, 3'b001, 3'b100, 0)); // round robin
        vecs.push_back(mk(0, 3'b111, 1, 1, 64'h2,                  1,   1, 3'b010, 3'b001, 0));
        vecs.push_back(mk(0, 3'b111, 1, 1, 64'h3,                  1,   2, 3'b100, 3'b010, 0));
        vecs.push_back(mk(0, 3'b111, 1, 1, 64'h4,                  1,   0, 3'b001, 3'b100, 0));
        vecs.push_back(mk(0, 3'b111, 1, 1, 64'h5,                  1,   1, 3'b010, 3'b001, 0)); // 10
        vecs.push_back(mk(0, 3'b111, 1, 1, 64'h6,                  1,   2, 3'b100, 3'b010, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'h7,                  0,   0, 3'b000, 3'b100, 0));
        vecs.push_back(mk(0, 3'b010, 1, 0, 64'h0,                  1,   1, 3'b010, 3'b000, 0)); // rr=2
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'h8,                  0,   0, 3'b000, 3'b010, 0));
        vecs.push_back(mk(0, 3'b101, 0, 0, 64'h0,                  1,   2, 3'b000, 3'b000, 0)); // 15 lock
        vecs.push_back(mk(0, 3'b101, 0, 0, 64'h0,                  1,   2, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b101, 0, 0, 64'h0,                  1,   2, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b101, 1, 0, 64'h0,                  1,   2, 3'b100, 3'b000, 0));
        vecs.push_back(mk(0, 3'b001, 1, 0, 64'h0,                  1,   0, 3'b001, 3'b000, 0));
        vecs.push_back(mk(0, 3'b111, 1, 0, 64'h0,                  0,   0, 3'b000, 3'b000, 0)); // 20 full
        vecs.push_back(mk(0, 3'b111, 1, 1, 64'h9,                  0,   0, 3'b000, 3'b100, 0));
        vecs.push_back(mk(0, 3'b111, 1, 0, 64'h0,                  1,   1, 3'b010, 3'b000, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'hA,                  0,   0, 3'b000, 3'b001, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'hB,                  0,   0, 3'b000, 3'b010, 0));
        vecs.push_back(mk(0, 3'b101, 1, 0, 64'h0,                  1,   2, 3'b100, 3'b000, 0)); // 25 routing
        vecs.push_back(mk(0, 3'b001, 1, 0, 64'h0,                  1,   0, 3'b001, 3'b000, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'hC,                  0,   0, 3'b000, 3'b100, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'hD,                  0,   0, 3'b000, 3'b001, 0));
        vecs.push_back(mk(0, 3'b001, 0, 0, 64'h0,                  1,   0, 3'b000, 3'b000, 0)); // lock vs rr
        vecs.push_back(mk(0, 3'b011, 0, 0, 64'h0,                  1,   0, 3'b000, 3'b000, 0)); // 30
        vecs.push_back(mk(0, 3'b011, 1, 0, 64'h0,                  1,   0, 3'b001, 3'b000, 0));
        vecs.push_back(mk(0, 3'b010, 1, 0, 64'h0,                  1,   1, 3'b010, 3'b000, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'hE,                  0,   0, 3'b000, 3'b001, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'hF,                  0,   0, 3'b000, 3'b010, 0));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'h10,                 0,   0, 3'b000, 3'b000, 0)); // 35 error
        vecs.push_back(mk(0, 3'b000, 0, 0, 64'h0,                  0,   0, 3'b000, 3'b000, 1));
        vecs.push_back(mk(0, 3'b000, 0, 0, 64'h0,                  0,   0, 3'b000, 3'b000, 1));
        vecs.push_back(mk(0, 3'b011, 1, 0, 64'h0,                  1,   0, 3'b001, 3'b000, 1));
        vecs.push_back(mk(0, 3'b010, 1, 0, 64'h0,                  1,   1, 3'b010, 3'b000, 1));
        vecs.push_back(mk(1, 3'b111, 1, 1, 64'h11,                 0,   0, 3'b000, 3'b000, 0)); // 40 reset
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'h12,                 0,   0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b111, 1, 0, 64'h0,                  1,   0, 3'b001, 3'b000, 1));
        vecs.push_back(mk(0, 3'b111, 1, 0, 64'h0,                  1,   1, 3'b010, 3'b000, 1));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'h13,                 0,   0, 3'b000, 3'b001, 1));
        vecs.push_back(mk(0, 3'b000, 0, 1, 64'h14,                 0,   0, 3'b000, 3'b010, 1)); // 45

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Lock held while a request that round-robin would prefer appears.
        apply(mk(0, 3'b011, 0, 0, 64'h0, 1, 0, 3'b000, 3'b000, 1), 100);
        for (int c = 0; c < 3; c++) begin
            apply(mk(0, 3'b111, 0, 0, 64'h0, 1, 0, 3'b000, 3'b000, 1), 101 + c);
        end
        apply(mk(0, 3'b111, 1, 0, 64'h0, 1, 0, 3'b001, 3'b000, 1), 104);

        // Port 0 withdraws; port 1 must be granted next within a bounded wait.
        @(negedge clk_i);
        req_i = 3'b110; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
        waited = 0;
        #1;
        while (gnt_o == 3'b000 && waited < 8) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        applied++;
        if (gnt_o !== 3'b010 || waited != 0) begin
            miscompares++;
            $display("FAIL post_lock_grant got %b after %0d cycles want 010 after 0", gnt_o, waited);
        end

        @(negedge clk_i);
        req_i = '0; mem_gnt_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
